// File: rtl/multi_timer_pkg.sv
// Shared register map and control-bit layout for the multi-channel timer.
package multi_timer_pkg;

  // Per-channel register indices (addr[1:0] when addr[4:2] < NCH)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_TARGET = 2'd2;

  // Global register indices (addr[1:0] when addr[4:2] == GLOBAL_CH)
  localparam logic [1:0] REG_PRESCALE = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;

  localparam logic [2:0] GLOBAL_CH = 3'd7;

  // CTRL bit positions
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;
  localparam int unsigned CTRL_W    = 3;

endpackage

// File: rtl/multi_timer_if.sv
// Data-bus side of the timer: register access plus flag/interrupt outputs.
interface multi_timer_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) ();

  logic             we;
  logic [4:0]       addr;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic [NCH-1:0]   flags;
  logic             irq;

  modport master (
    output we, addr, dataIn,
    input  dataOut, flags, irq
  );

  modport slave (
    input  we, addr, dataIn,
    output dataOut, flags, irq
  );

endinterface

// File: rtl/multi_timer_channel.sv
// One compare channel: count/target/ctrl registers and sticky match flag.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TICKS = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              wr_ctrl,
  input  logic              wr_count,
  input  logic              wr_target,
  input  logic              clr_flag,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  target,
  output logic [CTRL_W-1:0] ctrl,
  output logic              flag
);

  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              flag_q, flag_d;
  logic              match;

  // Match is judged on pre-write values so a same-cycle write never hides it
  assign match = tick && ctrl_q[CTRL_EN] && (count_q == target_q);

  // Next-state: hardware counting first, then software writes override
  always_comb begin
    count_d  = count_q;
    target_d = target_q;
    ctrl_d   = ctrl_q;
    flag_d   = flag_q;

    if (tick && ctrl_q[CTRL_EN]) begin
      if (match) begin
        if (ctrl_q[CTRL_AUTO]) count_d = '0;
        else                   ctrl_d[CTRL_EN] = 1'b0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    // Set after clear: a hardware match beats a same-cycle W1C
    if (clr_flag) flag_d = 1'b0;
    if (match)    flag_d = 1'b1;

    if (wr_count)  count_d  = wdata;
    if (wr_target) target_d = wdata;
    if (wr_ctrl)   ctrl_d   = wdata[CTRL_W-1:0];
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      target_q <= WIDTH'(TICKS);
      ctrl_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      target_q <= target_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
    end
  end

  assign count  = count_q;
  assign target = target_q;
  assign ctrl   = ctrl_q;
  assign flag   = flag_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel compare timer: shared prescaler, register decode, read mux, irq.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PW    = 16,
  parameter int unsigned TICKS = 500
) (
  input logic          clk,
  input logic          rst,
  multi_timer_if.slave bus
);

  logic [2:0]       ch;
  logic [1:0]       rg;
  logic             glb_wr;
  logic [PW-1:0]    prescale_q, prescale_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tick;
  logic [NCH-1:0]   flag;
  logic [NCH-1:0]   ie;
  logic [NCH-1:0]   clr;
  logic [WIDTH-1:0] count  [NCH];
  logic [WIDTH-1:0] target [NCH];
  logic [CTRL_W-1:0] ctrl  [NCH];
  logic [WIDTH-1:0] rdata;

  assign ch     = bus.addr[4:2];
  assign rg     = bus.addr[1:0];
  assign glb_wr = bus.we && (ch == GLOBAL_CH);
  assign tick   = (pcnt_q == prescale_q);

  // Prescaler next-state; a PRESCALE write restarts the divide phase
  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
    if (glb_wr && (rg == REG_PRESCALE)) begin
      prescale_d = bus.dataIn[PW-1:0];
      pcnt_d     = '0;
    end
  end

  // Prescaler registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel    = bus.we && (ch == 3'(i));
    assign clr[i] = glb_wr && (rg == REG_STATUS) && bus.dataIn[i];
    assign ie[i]  = ctrl[i][CTRL_IE];

    timer_channel #(
      .WIDTH (WIDTH),
      .TICKS (TICKS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .wr_ctrl   (sel && (rg == REG_CTRL)),
      .wr_count  (sel && (rg == REG_COUNT)),
      .wr_target (sel && (rg == REG_TARGET)),
      .clr_flag  (clr[i]),
      .wdata     (bus.dataIn),
      .count     (count[i]),
      .target    (target[i]),
      .ctrl      (ctrl[i]),
      .flag      (flag[i])
    );
  end

  // Combinational read mux; unmapped channels and the reserved slot read 0
  always_comb begin
    rdata = '0;
    if (ch == GLOBAL_CH) begin
      if (rg == REG_PRESCALE)    rdata = WIDTH'(prescale_q);
      else if (rg == REG_STATUS) rdata = WIDTH'(flag);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch == 3'(i)) begin
          case (rg)
            REG_CTRL:   rdata = WIDTH'(ctrl[i]);
            REG_COUNT:  rdata = count[i];
            REG_TARGET: rdata = target[i];
            default:    rdata = '0;
          endcase
        end
      end
    end
  end

  assign bus.dataOut = rdata;
  assign bus.flags   = flag;
  assign bus.irq     = |(flag & ie);

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed vector table, corner sequences, random vs model.
module tb_multi_timer;

  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned PW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_timer_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  multi_timer #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .PW    (PW),
    .TICKS (500)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state, kept at register-map level
  logic [31:0]    m_cnt [NCH];
  logic [31:0]    m_tgt [NCH];
  logic [2:0]     m_ctl [NCH];
  logic [NCH-1:0] m_flg;
  logic [15:0]    m_pre;
  logic [15:0]    m_pc;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [31:0] data;
    logic [4:0] raddr;
    logic [31:0] exp_rd;
    logic [3:0] exp_flags;
    logic       exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the timer's documented behaviour
  task automatic model_clock(input logic w, input logic [4:0] a, input logic [31:0] d,
                             input logic r);
    int ch;
    int rg;
    bit tick;
    logic [NCH-1:0] hit;
    ch = int'(a[4:2]);
    rg = int'(a[1:0]);
    if (!r) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 32'd0;
        m_tgt[i] = 32'd500;
        m_ctl[i] = 3'd0;
      end
      m_flg = '0;
      m_pre = 16'd0;
      m_pc  = 16'd0;
      return;
    end
    tick = (m_pc == m_pre);
    m_pc = tick ? 16'd0 : m_pc + 16'd1;
    hit  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tick && m_ctl[i][0]) begin
        if (m_cnt[i] == m_tgt[i]) begin
          hit[i] = 1'b1;
          if (m_ctl[i][1]) m_cnt[i] = 32'd0;
          else             m_ctl[i][0] = 1'b0;
        end else begin
          m_cnt[i] = m_cnt[i] + 32'd1;
        end
      end
    end
    if (w && ch == 7 && rg == 1) m_flg = m_flg & ~d[NCH-1:0];
    m_flg = m_flg | hit;
    if (w && ch == 7 && rg == 0) begin
      m_pre = d[15:0];
      m_pc  = 16'd0;
    end
    if (w && ch < NCH) begin
      case (rg)
        0: m_ctl[ch] = d[2:0];
        1: m_cnt[ch] = d;
        2: m_tgt[ch] = d;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int ch;
    int rg;
    ch = int'(a[4:2]);
    rg = int'(a[1:0]);
    if (ch == 7) begin
      if (rg == 0) return {16'h0, m_pre};
      if (rg == 1) return 32'(m_flg);
      return 32'd0;
    end
    if (ch >= NCH) return 32'd0;
    case (rg)
      0: return {29'h0, m_ctl[ch]};
      1: return m_cnt[ch];
      2: return m_tgt[ch];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq();
    logic v;
    v = 1'b0;
    for (int i = 0; i < NCH; i++) v = v | (m_flg[i] & m_ctl[i][2]);
    return v;
  endfunction

  // Drive one cycle's inputs, advance model and DUT, return 1ns after the edge
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic r = 1'b1);
    bus.we     = w;
    bus.addr   = a;
    bus.dataIn = d;
    rst        = r;
    model_clock(w, a, d, r);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    rst    = 1'b1;
  endtask

  task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    cmp(name, bus.dataOut, exp);
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    v = bus.dataOut;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] v;
    bus.we     = 1'b0;
    bus.addr   = 5'd0;
    bus.dataIn = 32'd0;

    // Table: reset readback, then ch1 auto-reload at PRESCALE=0
    tbl.push_back('{1'b0, 5'h02, 32'h0, 5'h02, 32'd500, 4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h00, 32'h0, 5'h00, 32'd0,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h01, 32'h0, 5'h01, 32'd0,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h1D, 32'h0, 5'h1D, 32'd0,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h1C, 32'h0, 5'h1C, 32'd0,   4'h0, 1'b0});
    tbl.push_back('{1'b1, 5'h06, 32'd3, 5'h06, 32'd3,   4'h0, 1'b0});
    tbl.push_back('{1'b1, 5'h04, 32'd7, 5'h05, 32'd0,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd1,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd2,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd3,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd0,   4'h2, 1'b1});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd1,   4'h2, 1'b1});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd2,   4'h2, 1'b1});
    tbl.push_back('{1'b1, 5'h1D, 32'd2, 5'h05, 32'd3,   4'h0, 1'b0});
    tbl.push_back('{1'b0, 5'h05, 32'h0, 5'h05, 32'd0,   4'h2, 1'b1});
    tbl.push_back('{1'b1, 5'h04, 32'd0, 5'h05, 32'd1,   4'h2, 1'b0});
    tbl.push_back('{1'b1, 5'h1D, 32'd2, 5'h04, 32'd0,   4'h0, 1'b0});

    step(1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    cmp("reset_irq", 32'(bus.irq), 32'd0);
    cmp("reset_flags", 32'(bus.flags), 32'd0);

    foreach (tbl[k]) begin
      step(tbl[k].we, tbl[k].addr, tbl[k].data);
      check_rd($sformatf("tbl%0d_rd", k), tbl[k].raddr, tbl[k].exp_rd);
      cmp($sformatf("tbl%0d_flags", k), 32'(bus.flags), 32'(tbl[k].exp_flags));
      cmp($sformatf("tbl%0d_irq", k), 32'(bus.irq), 32'(tbl[k].exp_irq));
    end

    // One-shot on ch0 with PRESCALE=4: one count step every 5 cycles
    step(1'b1, 5'h1C, 32'd4);
    step(1'b1, 5'h02, 32'd2);
    step(1'b1, 5'h00, 32'd1);
    n = 0;
    do begin
      step(1'b0, 5'h01, 32'd0);
      n++;
      peek(5'h01, v);
    end while (v != 32'd1 && n < 20);
    cmp("oneshot_first_tick", n, 32'd3);
    n = 0;
    do begin
      step(1'b0, 5'h01, 32'd0);
      n++;
      peek(5'h01, v);
    end while (v != 32'd2 && n < 20);
    cmp("oneshot_period", n, 32'd5);
    n = 0;
    do begin
      step(1'b0, 5'h01, 32'd0);
      n++;
    end while (bus.flags[0] !== 1'b1 && n < 20);
    cmp("oneshot_flag_delay", n, 32'd5);
    check_rd("oneshot_en_cleared", 5'h00, 32'd0);
    repeat (12) step(1'b0, 5'h01, 32'd0);
    check_rd("oneshot_count_hold", 5'h01, 32'd2);
    cmp("oneshot_flag_sticky", 32'(bus.flags), 32'h1);
    step(1'b1, 5'h1D, 32'h1);
    step(1'b1, 5'h1C, 32'd0);

    // ch2: W1C in the exact match cycle loses, one cycle later wins
    step(1'b1, 5'h0A, 32'd3);
    step(1'b1, 5'h08, 32'd3);
    repeat (3) step(1'b0, 5'h09, 32'd0);
    check_rd("w1c_pre_count", 5'h09, 32'd3);
    cmp("w1c_pre_flag", 32'(bus.flags[2]), 32'd0);
    step(1'b1, 5'h1D, 32'h4);
    cmp("w1c_set_wins", 32'(bus.flags[2]), 32'd1);
    step(1'b1, 5'h1D, 32'h4);
    cmp("w1c_later_clears", 32'(bus.flags[2]), 32'd0);
    step(1'b1, 5'h08, 32'd0);

    // ch3: count wraps through zero before matching a low target
    step(1'b1, 5'h0D, 32'hFFFF_FFFE);
    step(1'b1, 5'h0E, 32'd1);
    step(1'b1, 5'h0C, 32'd3);
    step(1'b0, 5'h0D, 32'd0);
    check_rd("wrap_ff", 5'h0D, 32'hFFFF_FFFF);
    step(1'b0, 5'h0D, 32'd0);
    check_rd("wrap_0", 5'h0D, 32'd0);
    step(1'b0, 5'h0D, 32'd0);
    check_rd("wrap_1", 5'h0D, 32'd1);
    cmp("wrap_no_flag_yet", 32'(bus.flags[3]), 32'd0);
    step(1'b0, 5'h0D, 32'd0);
    cmp("wrap_flag", 32'(bus.flags[3]), 32'd1);
    check_rd("wrap_reload", 5'h0D, 32'd0);

    // Reset mid-count with a write pending: write discarded
    step(1'b1, 5'h02, 32'd77, 1'b0);
    check_rd("rst_ch3_count", 5'h0D, 32'd0);
    check_rd("rst_ch3_ctrl", 5'h0C, 32'd0);
    check_rd("rst_write_lost", 5'h02, 32'd500);
    check_rd("rst_status", 5'h1D, 32'd0);
    cmp("rst_irq", 32'(bus.irq), 32'd0);

    // Unmapped channels and reserved slot: writes ignored, reads 0
    step(1'b1, 5'h14, 32'd7);
    step(1'b1, 5'h15, 32'd123);
    step(1'b1, 5'h16, 32'd9);
    step(1'b1, 5'h19, 32'd5);
    step(1'b1, 5'h03, 32'd55);
    check_rd("unmapped_ch5_ctrl", 5'h14, 32'd0);
    check_rd("unmapped_ch5_count", 5'h15, 32'd0);
    check_rd("unmapped_ch6_reg1", 5'h19, 32'd0);
    check_rd("reserved_reg3", 5'h03, 32'd0);
    step(1'b0, 5'h05, 32'd0);
    check_rd("no_alias_ch1_ctrl", 5'h04, 32'd0);
    check_rd("no_alias_ch1_count", 5'h05, 32'd0);
    check_rd("no_alias_ch1_target", 5'h06, 32'd500);

    // Random traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      logic        w;
      logic        r;
      logic [4:0]  a;
      logic [4:0]  ra;
      logic [31:0] d;
      w = (($urandom % 4) == 0);
      a = 5'($urandom % 32);
      r = (($urandom % 150) != 0);
      case (a[1:0])
        2'd0: d = (a[4:2] == 3'd7) ? ($urandom % 4) : ($urandom % 8);
        2'd1: d = (a[4:2] == 3'd7) ? $urandom :
                  (($urandom % 4) == 0) ? (32'hFFFF_FFFC + ($urandom % 4)) : ($urandom % 6);
        2'd2: d = $urandom % 6;
        default: d = $urandom;
      endcase
      step(w, a, d, r);
      cmp("rand_flags", 32'(bus.flags), 32'(m_flg));
      cmp("rand_irq", 32'(bus.irq), 32'(model_irq()));
      ra = 5'($urandom % 32);
      check_rd($sformatf("rand_rd_%02h", ra), ra, model_read(ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
